adc_frame_conditioner: RTL and testbench

//  Conditions the four raw 12-bit ADC channels (a0,a1,b0,b1) before the scope display.
//  The display samples its ad_* inputs once per frame, on the vsync rising edge.

---
 rtl/adc_frame_conditioner.sv | 138 +++++++++++++
 tb/tb_adc_frame_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_conditioner.sv
// adc_frame_conditioner
//   Conditions four raw 12-bit ADC channels for the scope display, which samples
//   ad_* once per frame on the vsync rising edge. Each channel offers four views,
//   chosen by mode: latest sample, 2^LOG2_AVG boxcar average, frame max, frame min.
// Ports
//   clk, reset       single clock; asynchronous active-low reset
//   vsync            frame marker (rising edge starts a new frame)
//   mode[1:0]        0 latest, 1 average, 2 frame max, 3 frame min
//   adc_valid        one-cycle strobe qualifying adc_a0/a1/b0/b1
//   ad_a0..ad_b1     conditioned outputs (registered)
//   avg_done         one-cycle pulse when a new block average has been loaded
//   frame_empty      set for the frame following a vsync-to-vsync span with no valid
module adc_frame_conditioner #(
  parameter int LOG2_AVG = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic [1:0]  mode,
  input  logic        adc_valid,
  input  logic [11:0] adc_a0,
  input  logic [11:0] adc_a1,
  input  logic [11:0] adc_b0,
  input  logic [11:0] adc_b1,
  output logic [11:0] ad_a0,
  output logic [11:0] ad_a1,
  output logic [11:0] ad_b0,
  output logic [11:0] ad_b1,
  output logic        avg_done,
  output logic        frame_empty
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 12;
  localparam int AW        = VEC_W + LOG2_AVG;

  logic [NUM_LANES-1:0][VEC_W-1:0] smp, ad;

  logic                vsync_d1;
  logic [1:0]          mode_d1;
  logic [LOG2_AVG-1:0] cnt;
  logic                pk_live;   // 0: next accepted valid (re)loads the trackers
  logic                seen;      // current frame has had an accepted valid
  logic                vs_rise, flush, acc_en, cnt_last, pk_load, cap;

  assign smp = {adc_b1, adc_b0, adc_a1, adc_a0};
  assign {ad_b1, ad_b0, ad_a1, ad_a0} = ad;

  assign vs_rise  = vsync & ~vsync_d1;
  assign flush    = (mode != mode_d1);
  // A valid in a flush cycle is dropped by the average and peak paths only.
  assign acc_en   = adc_valid & ~flush;
  assign cnt_last = &cnt;
  // A valid coincident with vs_rise opens the new frame, so it loads.
  assign pk_load  = ~pk_live | vs_rise;
  assign cap      = vs_rise & seen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_d1    <= 1'b0;
      mode_d1     <= 2'd0;
      cnt         <= '0;
      pk_live     <= 1'b0;
      seen        <= 1'b0;
      avg_done    <= 1'b0;
      frame_empty <= 1'b0;
    end else begin
      vsync_d1 <= vsync;
      mode_d1  <= mode;
      avg_done <= acc_en & cnt_last;
      // Count wraps naturally from all-ones to zero on the completing valid.
      if (flush)       cnt <= '0;
      else if (acc_en) cnt <= cnt + 1'b1;
      if (vs_rise || flush) pk_live <= acc_en;
      else if (acc_en)      pk_live <= 1'b1;
      if (vs_rise)     seen <= acc_en;
      else if (acc_en) seen <= 1'b1;
      if (vs_rise) frame_empty <= ~seen;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [AW-1:0]    acc, sum;
    logic [VEC_W-1:0] last, avg, pk_max, pk_min, hold_max, hold_min, ad_q;

    assign sum   = acc + AW'(smp[i]);
    assign ad[i] = ad_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc      <= '0;
        last     <= '0;
        avg      <= '0;
        pk_max   <= '0;
        pk_min   <= '0;
        hold_max <= '0;
        hold_min <= '0;
        ad_q     <= '0;
      end else begin
        if (adc_valid) last <= smp[i];

        if (flush) acc <= '0;
        else if (acc_en) begin
          if (cnt_last) begin
            avg <= sum[AW-1:LOG2_AVG];
            acc <= '0;
          end else begin
            acc <= sum;
          end
        end

        if (acc_en) begin
          if (pk_load) begin
            pk_max <= smp[i];
            pk_min <= smp[i];
          end else begin
            if (smp[i] > pk_max) pk_max <= smp[i];
            if (smp[i] < pk_min) pk_min <= smp[i];
          end
        end

        // Trackers still hold the ending frame here; a coincident valid
        // only lands in them after this edge.
        if (cap) begin
          hold_max <= pk_max;
          hold_min <= pk_min;
        end

        unique case (mode_d1)
          2'd0:    ad_q <= last;
          2'd1:    ad_q <= avg;
          2'd2:    ad_q <= hold_max;
          default: ad_q <= hold_min;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_conditioner.sv
module tb_adc_frame_conditioner;
  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic [1:0]  mode;
  logic        adc_valid;
  logic [11:0] adc_a0, adc_a1, adc_b0, adc_b1;
  logic [11:0] ad_a0, ad_a1, ad_b0, ad_b1;
  logic        avg_done, frame_empty;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  typedef struct {
    logic        vld;
    logic [47:0] in;   // {b1,b0,a1,a0}
    logic [47:0] exp;  // {b1,b0,a1,a0}
  } vec_t;

  localparam int NV = 6;
  vec_t        tbl[NV];
  logic [47:0] sb[$];
  logic [47:0] ad_all;
  assign ad_all = {ad_b1, ad_b0, ad_a1, ad_a0};

  always #5 clk = ~clk;

  always @(posedge clk) if (avg_done) done_cnt <= done_cnt + 1;

  adc_frame_conditioner #(.LOG2_AVG(4)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .mode(mode), .adc_valid(adc_valid),
    .adc_a0(adc_a0), .adc_a1(adc_a1), .adc_b0(adc_b0), .adc_b1(adc_b1),
    .ad_a0(ad_a0), .ad_a1(ad_a1), .ad_b0(ad_b0), .ad_b1(ad_b1),
    .avg_done(avg_done), .frame_empty(frame_empty)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [11:0] a0, input logic [11:0] a1,
                      input logic [11:0] b0, input logic [11:0] b1);
    adc_a0 = a0; adc_a1 = a1; adc_b0 = b0; adc_b1 = b1;
    adc_valid = 1'b1;
    tick;
    adc_valid = 1'b0;
  endtask

  task automatic vs_pulse;
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
    tick;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    tick;
    tick;
  endtask

  initial begin
    int          d0;
    logic [47:0] e;
    logic [11:0] pre;

    tbl[0] = '{1'b1, {12'h789, 12'h456, 12'h123, 12'hABC}, {12'h789, 12'h456, 12'h123, 12'hABC}};
    tbl[1] = '{1'b0, {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, {12'h789, 12'h456, 12'h123, 12'hABC}};
    tbl[2] = '{1'b1, {12'h800, 12'h001, 12'hFFF, 12'h000}, {12'h800, 12'h001, 12'hFFF, 12'h000}};
    tbl[3] = '{1'b1, {12'h001, 12'h7FF, 12'h000, 12'hFFF}, {12'h001, 12'h7FF, 12'h000, 12'hFFF}};
    tbl[4] = '{1'b0, {12'h000, 12'h000, 12'h000, 12'h000}, {12'h001, 12'h7FF, 12'h000, 12'hFFF}};
    tbl[5] = '{1'b1, {12'h000, 12'h000, 12'h000, 12'h000}, {12'h000, 12'h000, 12'h000, 12'h000}};

    reset = 1'b0; vsync = 1'b0; mode = 2'd0; adc_valid = 1'b0;
    adc_a0 = '0; adc_a1 = '0; adc_b0 = '0; adc_b1 = '0;
    tick; tick;
    chk("reset ad", ad_all, 48'd0);
    chk("reset avg_done", {47'd0, avg_done}, 48'd0);
    chk("reset frame_empty", {47'd0, frame_empty}, 48'd0);
    reset = 1'b1;
    tick;

    // Latest view, table-driven through a scoreboard: 2-cycle latency.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        {adc_b1, adc_b0, adc_a1, adc_a0} = tbl[i].in;
        adc_valid = tbl[i].vld;
        sb.push_back(tbl[i].exp);
      end else begin
        adc_valid = 1'b0;
      end
      tick;
      if (i >= 1) begin
        e = sb.pop_front();
        chk($sformatf("latest vec %0d", i - 1), ad_all, e);
      end
    end
    adc_valid = 1'b0;

    // Single valid 0xABC: not visible after 1 clk, visible after 2.
    send(12'hABC, 12'd0, 12'd0, 12'd0);
    chk("latest 1clk", {36'd0, ad_a0}, 48'd0);
    tick;
    chk("latest 2clk", {36'd0, ad_a0}, 48'hABC);

    // Average view: 15 valids no change, 16th loads.
    set_mode(2'd1);
    d0 = done_cnt;
    for (int i = 0; i < 15; i++)
      send(12'(100 + i), 12'(4000 + i), 12'(i * 200), 12'd4095);
    tick;
    chk("avg 15 no done", 48'(done_cnt - d0), 48'd0);
    chk("avg 15 no change", {36'd0, ad_a0}, 48'd0);
    send(12'd115, 12'd4015, 12'd3000, 12'd4095);
    chk("avg_done pulse", {47'd0, avg_done}, 48'd1);
    tick;
    chk("avg_done single", {47'd0, avg_done}, 48'd0);
    chk("avg values", ad_all, {12'd4095, 12'd1500, 12'd4007, 12'd107});
    chk("avg one pulse", 48'(done_cnt - d0), 48'd1);

    // Reset mid-block (count=7): outputs clear at once, next block needs 16.
    for (int i = 0; i < 7; i++) send(12'd1000, 12'd0, 12'd0, 12'd0);
    #2 reset = 1'b0;
    #1;
    chk("async reset ad", ad_all, 48'd0);
    chk("async reset flags", {46'd0, avg_done, frame_empty}, 48'd0);
    mode = 2'd0;
    tick;
    reset = 1'b1;
    tick;
    d0 = done_cnt;
    for (int i = 0; i < 15; i++) send(12'd2000, 12'd0, 12'd0, 12'd0);
    tick;
    chk("post-reset 15 no done", 48'(done_cnt - d0), 48'd0);
    send(12'd2000, 12'd0, 12'd0, 12'd0);
    tick;
    chk("post-reset 16 done", 48'(done_cnt - d0), 48'd1);
    set_mode(2'd1);
    chk("post-reset avg", {36'd0, ad_a0}, 48'd2000);

    // Mode change 1->0 mid-block flushes count and accumulator.
    for (int i = 0; i < 8; i++) send(12'd500, 12'd0, 12'd0, 12'd0);
    set_mode(2'd0);
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) send(12'd3000, 12'd0, 12'd0, 12'd0);
    tick;
    chk("flush restart no early done", 48'(done_cnt - d0), 48'd0);
    for (int i = 0; i < 8; i++) send(12'd3000, 12'd0, 12'd0, 12'd0);
    tick;
    chk("flush restart done", 48'(done_cnt - d0), 48'd1);
    set_mode(2'd1);
    chk("flush restart avg", {36'd0, ad_a0}, 48'd3000);

    // Peak views.
    set_mode(2'd2);
    vs_pulse;
    pre = ad_b1;
    send(12'd0, 12'd200, 12'd0, 12'd5);
    send(12'd0, 12'd100, 12'd0, 12'd4095);
    send(12'd0, 12'd150, 12'd0, 12'd300);
    chk("peak stable in frame", {36'd0, ad_b1}, {36'd0, pre});
    vsync = 1'b1;
    tick;
    chk("peak not at vs edge", {36'd0, ad_b1}, {36'd0, pre});
    tick;
    vsync = 1'b0;
    chk("frame max b1", {36'd0, ad_b1}, 48'd4095);
    chk("frame max a1", {36'd0, ad_a1}, 48'd200);
    chk("frame_empty clear", {47'd0, frame_empty}, 48'd0);
    set_mode(2'd3);
    chk("frame min b1", {36'd0, ad_b1}, 48'd5);
    chk("frame min a1", {36'd0, ad_a1}, 48'd100);

    // Valid coincident with vs_rise belongs to the new frame.
    set_mode(2'd2);
    send(12'd0, 12'd200, 12'd0, 12'd0);
    send(12'd0, 12'd150, 12'd0, 12'd0);
    vsync = 1'b1;
    adc_a1 = 12'd4000;
    adc_valid = 1'b1;
    tick;
    adc_valid = 1'b0;
    vsync = 1'b0;
    tick;
    chk("coincident excluded", {36'd0, ad_a1}, 48'd200);
    send(12'd0, 12'd10, 12'd0, 12'd0);
    vs_pulse;
    chk("coincident in next frame", {36'd0, ad_a1}, 48'd4000);

    // Empty frame holds peaks and flags frame_empty; next populated frame clears it.
    chk("populated not empty", {47'd0, frame_empty}, 48'd0);
    vs_pulse;
    chk("empty frame flag", {47'd0, frame_empty}, 48'd1);
    chk("empty frame holds peak", {36'd0, ad_a1}, 48'd4000);
    send(12'd0, 12'd50, 12'd0, 12'd0);
    vs_pulse;
    chk("refilled frame flag", {47'd0, frame_empty}, 48'd0);
    chk("refilled frame peak", {36'd0, ad_a1}, 48'd50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
